fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Downstream drain stage for the 16x8 sync FIFO. Pops one byte at a time when the FIFO
//   reports non-empty, then serialises it onto a UART line (8N1, LSB first).
//   Sits between the FIFO read port and the chip-level TX pin. Owns the FIFO rd_en.
// PARAMETERS
//   DATA_W        8   payload bits per frame; must match the FIFO word width
//   CLKS_PER_BIT  16  clk cycles per serial bit; legal range 2..65535
//   STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//   clk          in   1       system clock; all logic on posedge
//   reset        in   1       asynchronous, active-low reset
//   fifo_empty   in   1       FIFO empty flag (registered in the FIFO)
//   fifo_data    in   DATA_W  FIFO output_data; valid the cycle after rd_en
//   fifo_rd_en   out  1       single-cycle pop request to the FIFO
//   tx           out  1       serial line; idle high
//   busy         out  1       high from POP until the last stop bit completes
//   frame_done   out  1       1-cycle pulse in the final cycle of the last stop bit
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0,
//     counters=0, shift reg=0. Takes effect immediately, not at the clock edge.
//   FSM states: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   tx=1. If fifo_empty==0, go to POP at the next edge.
//   POP:    fifo_rd_en=1 for exactly this cycle; busy=1. Always go to LOAD next.
//   LOAD:   fifo_data is valid this cycle; capture it into the shift reg at the edge; go to START.
//   START:  tx=0 for CLKS_PER_BIT cycles.
//   DATA:   tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right; DATA_W bits, LSB first.
//   STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses in the final cycle.
//   Exit:   next state is IDLE, never POP directly.
//   Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change.
//     Bit counter: 0..DATA_W-1, wraps only via the state change.
//   Pop-to-first-start-bit latency: 2 cycles (POP, LOAD). Frame length, excluding POP/LOAD/IDLE:
//     (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
//   Stale empty flag: the FIFO empty flag lags the pop by 2 edges. This is harmless because
//     a frame is at least 20 cycles and IDLE always lasts at least 1 cycle.
//   Back-to-back bytes: the stop bit is followed by 1 IDLE cycle, then POP.
//     Gap between frames is 3 cycles of tx=1.
//   FIFO empty mid-frame: no effect; the current frame completes.
//     fifo_empty is sampled only in IDLE.
//   Reset mid-frame: the line returns high at once. The popped byte is discarded, not re-queued.
//   tx, fifo_rd_en and frame_done are registered outputs (no combinational path from inputs).
// CONFIGURATION
//   PARITY_EN defined: a PARITY state is inserted after DATA.
//     tx = XOR of the DATA_W data bits (even parity) for CLKS_PER_BIT cycles.
//     Frame grows by one bit-time.
//   PARITY_EN undefined: no PARITY state and no parity logic; DATA goes straight to STOP.
// STRUCTURE
//   fifo_uart_pkg: state enum (IDLE, POP, LOAD, START, DATA, PARITY, STOP), state width,
//     and IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants.
//   Sub-module uart_baud_cnt: parameterised CLKS_PER_BIT counter.
//     Inputs: clr. Outputs: bit_end pulse. Reused later by the matching RX block.
//   The FSM, shift register, bit counter and parity accumulator stay in fifo_uart_tx.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1, behavioural FIFO model)
//   1. Reset held, fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0.
//      No pop occurs until reset=1.
//   2. Push 0xA5 -> exactly one rd_en pulse. tx shows 0 | 1,0,1,0,0,1,0,1 | 1, each bit 4 cycles.
//      frame_done pulses once.
//   3. Push 0x00,0xFF,0x3C back-to-back -> 3 frames in order with 3-cycle idle gaps.
//      3 rd_en pulses, no pop while the FIFO is empty.
//   4. Assert reset during DATA bit 3 of 0x5A -> tx=1 in the same cycle, busy=0.
//      After release, the next FIFO byte is sent intact.
//   5. PARITY_EN defined, send 0x07 -> parity bit=1, frame=11 bit-times.
//      Send 0x03 -> parity bit=0.
//   6. FIFO held empty for 200 cycles -> fifo_rd_en never asserts, tx constantly 1.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
//   Shared definitions for the FIFO-drain UART transmitter (and its future RX
//   sibling): FSM state encoding plus the line levels used for idle, start and
//   stop bits.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
//   Free-running bit-time counter, 0..CLKS_PER_BIT-1, wrapping to 0. A clear
//   forces the count back to 0 so each new bit period starts aligned.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous, active-low reset
//     clr       in   restart the bit period (count <= 0 at the edge)
//     bit_end   out  high in the last cycle of a bit period
//     near_end  out  high in the second-to-last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end,
  output logic near_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end  = (cnt_q == CNT_LAST);
  // Lets the parent register an output that must be high in the last cycle.
  assign near_end = (cnt_q == CNT_NEAR);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for the sync FIFO: pops one byte whenever the FIFO is non-empty
//   and the transmitter is idle, then sends it as an 8N1 UART frame, LSB first.
//   Optional even parity bit after the data bits when PARITY_EN is defined.
//   Ports:
//     clk         in   system clock, posedge
//     reset       in   asynchronous, active-low reset
//     fifo_empty  in   FIFO empty flag (registered in the FIFO)
//     fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en  out  one-cycle pop request (registered)
//     tx          out  serial line, idle high (registered)
//     busy        out  high from POP until the last stop bit completes
//     frame_done  out  pulse in the final cycle of the last stop bit (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BIT_CNT_W = $clog2((DATA_W > 2) ? DATA_W : 2);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  state_e                state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic                  state_change;
  logic                  bit_end;
  logic                  near_end;
`ifdef PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Bit period restarts on every state change so each field is exactly one bit-time.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_change),
    .bit_end (bit_end),
    .near_end(near_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        state_d = START;
`ifdef PARITY_EN
        parity_d = 1'b0;
`endif
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
`ifdef PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (bit_cnt_q == LAST_DATA) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    state_change = (state_d != state_q);
    if (state_change) begin
      bit_cnt_d = '0;
    end
  end

  // Outputs are computed from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    rd_en_d = (state_d == POP);
    // near_end in the last stop bit means the next cycle is the frame's final one.
    done_d  = (state_q == STOP) && near_end && (bit_cnt_q == LAST_STOP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= IDLE_LEVEL;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
`ifdef PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO model (CLKS_PER_BIT=4).
module tb_fifo_uart_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FCYC = FB * CPB;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_rd_en;
  logic              tx;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int rd_count = 0;
  int underflow = 0;
  int last_rd_neg = 0;
  logic [7:0] q[$];

  fifo_uart_tx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data and empty flag.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && q.size() > 0) fifo_data <= q.pop_front();
    fifo_empty <= (q.size() == 0);
  end

  always @(negedge clk) begin
    neg_cnt++;
    if (fifo_rd_en === 1'b1) begin
      rd_count++;
      last_rd_neg = neg_cnt;
      if (q.size() == 0) underflow++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [FB-1:0] frame_bits(input logic [7:0] d);
`ifdef PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Waits (bounded) for a start bit and records one level per bit-time.
  task automatic capture(output logic [FB-1:0] lv, output bit stable, output int done_cnt,
                         output int lat, output bit busy_ok, output bit tmo);
    int w = 0;
    lv = '0; stable = 1'b1; done_cnt = 0; lat = 0; busy_ok = 1'b1; tmo = 1'b0;
    while (tx !== 1'b0 && w < 400) begin
      tick();
      w++;
    end
    if (tx !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    lat = neg_cnt - last_rd_neg;
    for (int i = 0; i < FCYC; i++) begin
      if (i > 0) tick();
      if (i % CPB == 0) lv[i/CPB] = tx;
      else if (tx !== lv[i/CPB]) stable = 1'b0;
      if (frame_done === 1'b1) done_cnt += (i == FCYC - 1) ? 1 : 100;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic measure_gap(output int gap);
    gap = 0;
    tick();
    while (tx === 1'b1 && gap < 50) begin
      gap++;
      tick();
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    #1;
    q.push_back(8'hA5);
    repeat (6) begin
      tick();
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_hold: got %0d bad cycles, expected 0", bad);
    end
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (rd_count !== 0) begin
      errors++; $display("FAIL reset_no_pop: got %0d pops expected 0", rd_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [FB-1:0] lv; bit st, bo, tmo; int dc, lat;
    int rd0 = rd_count;
    capture(lv, st, dc, lat, bo, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL single_start: no start bit seen"); end
    checks++;
    if (lv !== frame_bits(8'hA5)) begin
      errors++; $display("FAIL single_bits: got %b expected %b", lv, frame_bits(8'hA5));
    end
    checks++;
    if (!st) begin errors++; $display("FAIL single_bit_width: got unstable bits expected 4-cycle"); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL single_frame_done: got %0d expected 1", dc); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", lat); end
    checks++;
    if (!bo) begin errors++; $display("FAIL single_busy: got busy low in frame expected high"); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    checks++;
    if (rd_count - rd0 !== 1) begin
      errors++; $display("FAIL single_pops: got %0d expected 1", rd_count - rd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
    logic [FB-1:0] lv; bit st, bo, tmo; int dc, lat, gap;
    int rd0 = rd_count;
    int uf0 = underflow;
    for (int f = 0; f < 3; f++) q.push_back(bytes[f]);
    for (int f = 0; f < 3; f++) begin
      capture(lv, st, dc, lat, bo, tmo);
      checks++;
      if (tmo || lv !== frame_bits(bytes[f]) || !st) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %b expected %b (tmo %0d)", f, lv, frame_bits(bytes[f]),
                 tmo);
      end
      checks++;
      if (dc !== 1) begin errors++; $display("FAIL b2b_done%0d: got %0d expected 1", f, dc); end
      if (f < 2) begin
        measure_gap(gap);
        checks++;
        if (gap !== 3) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 3", f, gap); end
      end
    end
    repeat (10) tick();
    checks++;
    if (rd_count - rd0 !== 3) begin
      errors++; $display("FAIL b2b_pops: got %0d expected 3", rd_count - rd0);
    end
    checks++;
    if (underflow !== uf0) begin
      errors++; $display("FAIL b2b_underflow: got %0d expected %0d", underflow, uf0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [FB-1:0] lv; bit st, bo, tmo; int dc, lat;
    int w = 0;
    int rd0;
    q.push_back(8'h5A);
    q.push_back(8'hC3);
    while (tx !== 1'b0 && w < 400) begin tick(); w++; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midrst_start: no start bit seen"); end
    repeat (17) tick();  // inside data bit 3
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++;
    if (fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got rd_en %b done %b expected 0 0", fifo_rd_en,
                         frame_done);
    end
    repeat (3) tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_hold: got tx %b busy %b expected 1 0", tx, busy);
    end
    rd0 = rd_count;
    reset = 1'b1;
    capture(lv, st, dc, lat, bo, tmo);
    checks++;
    if (tmo || lv !== frame_bits(8'hC3) || !st) begin
      errors++; $display("FAIL midrst_next: got %b expected %b", lv, frame_bits(8'hC3));
    end
    tick();
    checks++;
    if (rd_count - rd0 !== 1 || q.size() !== 0) begin
      errors++; $display("FAIL midrst_pops: got %0d pops, %0d left expected 1, 0",
                         rd_count - rd0, q.size());
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [FB-1:0] lv; bit st, bo, tmo; int dc, lat;
    q.push_back(8'h07);
    capture(lv, st, dc, lat, bo, tmo);
    checks++;
    if (tmo || lv[9] !== 1'b1 || lv !== frame_bits(8'h07)) begin
      errors++; $display("FAIL parity_07: got %b expected %b", lv, frame_bits(8'h07));
    end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL parity_len: got %0d expected 1", dc); end
    repeat (4) tick();
    q.push_back(8'h03);
    capture(lv, st, dc, lat, bo, tmo);
    checks++;
    if (tmo || lv[9] !== 1'b0 || lv !== frame_bits(8'h03)) begin
      errors++; $display("FAIL parity_03: got %b expected %b", lv, frame_bits(8'h03));
    end
    repeat (4) tick();
  endtask
`endif

  task automatic test_idle_empty();
    int bad_rd = 0;
    int bad_tx = 0;
    repeat (5) tick();
    repeat (200) begin
      tick();
      if (fifo_rd_en !== 1'b0) bad_rd++;
      if (tx !== 1'b1) bad_tx++;
    end
    checks++;
    if (bad_rd !== 0) begin errors++; $display("FAIL idle_rd_en: got %0d expected 0", bad_rd); end
    checks++;
    if (bad_tx !== 0) begin errors++; $display("FAIL idle_tx: got %0d expected 0", bad_tx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PARITY_EN
    test_parity();
`endif
    test_idle_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
